// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg: shared FSM state encoding and fixed APB5 sideband values
package apb_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAKE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    localparam logic [2:0] PPROT_DEFAULT  = 3'b000;
    localparam logic       PWUSER_DEFAULT = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i
//   req_i   : request vector, one bit per requester
//   ptr_i   : index holding highest priority this round
//   gnt_o   : one-hot grant (zero when nothing requests)
//   idx_o   : binary index of the granted requester
//   valid_o : any request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               valid_o
);

    logic          hi;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Scanning downward leaves the lowest matching index in each candidate:
    // hi_idx is the first request at or after the pointer, lo_idx the wrap-around choice.
    always_comb begin
        hi     = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                lo_idx = IW'(k);
                if (IW'(k) >= ptr_i) begin
                    hi     = 1'b1;
                    hi_idx = IW'(k);
                end
            end
        end
    end

    assign valid_o = |req_i;
    assign idx_o   = hi ? hi_idx : lo_idx;
    assign gnt_o   = NUM_REQ'(valid_o) << idx_o;

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin sharing of one APB5 slave among NUM_REQ requesters
//   PCLK, PRESET              : clock, asynchronous active-high reset
//   req_valid/req_ready       : per-requester handshake, accepted only while idle
//   req_write/addr/wdata/strb/auser : flattened per-requester request fields
//   rsp_valid/rsp_rdata/rsp_err : one-cycle completion pulse to the granted requester
//   PSEL..PPARITY, PADDR..PWUSER : APB5 request side (registered, held after a transfer)
//   PRDATA, PREADY, PSLVERR, PPARERR : APB5 completion side
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int USER_REQ_WIDTH  = 8,
    parameter int USER_DATA_WIDTH = DATA_WIDTH / 2,
    parameter int TIMEOUT         = 16
) (
    input  logic                              PCLK,
    input  logic                              PRESET,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]     req_strb,
    input  logic [NUM_REQ*USER_REQ_WIDTH-1:0] req_auser,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_err,
    output logic                              PSEL,
    output logic                              PENABLE,
    output logic                              PWRITE,
    output logic                              PWAKEUP,
    output logic                              PPARITY,
    output logic [ADDR_WIDTH-1:0]             PADDR,
    output logic [DATA_WIDTH-1:0]             PWDATA,
    output logic [STRB_WIDTH-1:0]             PSTRB,
    output logic [2:0]                        PPROT,
    output logic [USER_REQ_WIDTH-1:0]         PAUSER,
    output logic [USER_DATA_WIDTH-1:0]        PWUSER,
    input  logic [DATA_WIDTH-1:0]             PRDATA,
    input  logic                              PREADY,
    input  logic                              PSLVERR,
    input  logic                              PPARERR
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    state_e                    state_q, state_d;
    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]             gidx_q, gidx_d;
    logic                      awake_q, awake_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic                      pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]     pstrb_q, pstrb_d;
    logic [USER_REQ_WIDTH-1:0] pauser_q, pauser_d;

    logic [NUM_REQ-1:0]        arb_gnt;
    logic [IW-1:0]             arb_idx;
    logic                      arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_any)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            awake_q  <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pauser_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            awake_q  <= awake_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            pauser_q <= pauser_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gidx_d    = gidx_q;
        awake_d   = awake_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pauser_d  = pauser_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    req_ready = arb_gnt;
                    gidx_d    = arb_idx;
                    pwrite_d  = req_write[arb_idx];
                    paddr_d   = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_d  = req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                    pstrb_d   = req_strb[arb_idx*STRB_WIDTH +: STRB_WIDTH];
                    pauser_d  = req_auser[arb_idx*USER_REQ_WIDTH +: USER_REQ_WIDTH];
                    state_d   = awake_q ? ST_SETUP : ST_WAKE;
                end
            end
            ST_WAKE: begin
                awake_d = 1'b1;
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY wins over the timeout on the last allowed cycle
                if (PREADY) begin
                    err_d   = PSLVERR | PPARERR;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                rr_ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign PWAKEUP   = (state_q == ST_WAKE) || PSEL;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PAUSER    = pauser_q;
    assign PPROT     = PPROT_DEFAULT;
    assign PWUSER    = {USER_DATA_WIDTH{PWUSER_DEFAULT}};
    assign PPARITY   = ^{PADDR, PWRITE, PSTRB, PPROT, PWDATA, PAUSER, PWUSER};
    assign rsp_valid = (state_q == ST_RESP) ? NUM_REQ'(1) << gidx_q : '0;
    // The slave updates PRDATA on the completing edge, so it is passed through live
    assign rsp_rdata = (state_q == ST_RESP) ? PRDATA : '0;
    assign rsp_err   = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: random requesters against a memory slave, scoreboarded responses
module tb_apb_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int UW = 8;
    localparam int WW = 16;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*SW-1:0] req_strb = '0;
    logic [N*UW-1:0] req_auser = '0;
    logic [N-1:0]  req_ready, rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, PSEL, PENABLE, PWRITE, PWAKEUP, PPARITY;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [2:0]    PPROT;
    logic [UW-1:0] PAUSER;
    logic [WW-1:0] PWUSER;
    bit   [DW-1:0] prdata;
    logic          PREADY, PSLVERR, PPARERR;

    apb_master_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
        .USER_REQ_WIDTH(UW), .USER_DATA_WIDTH(WW), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_auser(req_auser),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWAKEUP(PWAKEUP), .PPARITY(PPARITY),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PAUSER(PAUSER),
        .PWUSER(PWUSER), .PRDATA(prdata), .PREADY(PREADY), .PSLVERR(PSLVERR), .PPARERR(PPARERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Memory slave: 1024 words, byte strobes, out-of-range access errors with DEADBEEF
    bit [31:0] mem [1024];
    int sl_wait;
    bit sl_perr;
    int acc_cyc;
    assign PREADY  = PSEL && PENABLE && (acc_cyc >= sl_wait);
    assign PSLVERR = PREADY && (PADDR >= 1024);
    assign PPARERR = PREADY && sl_perr;

    always @(posedge PCLK) begin
        acc_cyc <= (PSEL && PENABLE && !PREADY) ? acc_cyc + 1 : 0;
        if (PSEL && PENABLE && PREADY) begin
            if (!PWRITE)
                prdata <= (PADDR >= 1024) ? 32'hDEAD_BEEF : mem[PADDR[9:0]];
            else if (PADDR < 1024)
                for (int b = 0; b < SW; b++)
                    if (PSTRB[b]) mem[PADDR[9:0]][8*b +: 8] <= PWDATA[8*b +: 8];
        end
    end

    int n_chk, n_fail;

    task automatic chk(input string nm, input logic [191:0] a, input logic [191:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    typedef struct {
        int      idx;
        bit [31:0] rdata;
        bit      care;
        bit      err;
        int      cyc;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    // Pending request per requester, with the slave behaviour it will meet
    bit        pv [N];
    bit        pw [N];
    bit [31:0] pa [N];
    bit [31:0] pd [N];
    bit [3:0]  ps [N];
    bit [7:0]  pu [N];
    int        pwt [N];
    bit        ppe [N];

    // Reference model state
    int        ptr, idle_at;
    bit        awake;
    bit [31:0] mm [1024];
    bit        cw;
    bit [31:0] ca, cd;
    bit [3:0]  cs;
    bit [7:0]  cu;

    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else begin
                    me = sb.pop_front();
                    chk("rsp_valid", rsp_valid, N'(1) << me.idx);
                    chk("rsp_err", rsp_err, me.err);
                    if (me.care) chk("rsp_rdata", rsp_rdata, me.rdata);
                    chk("rsp_cycle", cyc, me.cyc);
                end
            end else chk("rsp_rdata_idle", {rsp_rdata, rsp_err}, 0);
            if (PSEL) begin
                chk("apb_fields", {PWRITE, PADDR, PWDATA, PSTRB, PAUSER, PPROT, PWUSER, PWAKEUP},
                    {cw, ca, cd, cs, cu, 3'b000, 16'h0, 1'b1});
                chk("pparity", PPARITY, ^{ca, cw, cs, 3'b000, cd, cu, 16'h0});
            end
        end
    end

    task automatic issue(input int i, input bit w, input bit [31:0] a, input bit [31:0] d,
                         input bit [3:0] s, input bit [7:0] u, input int wt, input bit pe);
        pv[i] = 1; pw[i] = w; pa[i] = a; pd[i] = d; ps[i] = s; pu[i] = u; pwt[i] = wt; ppe[i] = pe;
    endtask

    task automatic new_req(input int i);
        int r;
        r = $urandom_range(0, 9);
        issue(i, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 32'd2000 : 32'($urandom_range(0, 15)),
              $urandom, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
              (r < 5) ? 0 : (r == 5) ? 1 : (r == 6) ? 3 : (r == 7) ? TO - 1 : (r == 8) ? TO + 4 : 2,
              $urandom_range(0, 9) == 0);
    endtask

    task automatic grant(input int g);
        exp_t e;
        bit to, oob;
        int lat;
        to  = pwt[g] >= TO;
        oob = pa[g] >= 1024;
        lat = (awake ? 0 : 1) + (to ? TO + 2 : 3 + pwt[g]);
        e.idx   = g;
        e.err   = to | oob | ppe[g];
        e.care  = !pw[g] && !to;
        e.rdata = oob ? 32'hDEAD_BEEF : mm[pa[g][9:0]];
        e.cyc   = cyc + lat;
        if (pw[g] && !to && !oob)
            for (int b = 0; b < SW; b++)
                if (ps[g][b]) mm[pa[g][9:0]][8*b +: 8] = pd[g][8*b +: 8];
        sb.push_back(e);
        cw = pw[g]; ca = pa[g]; cd = pd[g]; cs = ps[g]; cu = pu[g];
        sl_wait = pwt[g];
        sl_perr = ppe[g];
        ptr     = (g + 1) % N;
        awake   = 1;
        idle_at = cyc + lat + 1;
        pv[g]   = 0;
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < N; i++) p |= pv[i];
        return p;
    endfunction

    task automatic step(input bit refill);
        int g;
        @(negedge PCLK);
        if (refill)
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) new_req(i);
                else if (pv[i] && $urandom_range(0, 31) == 0) pv[i] = 0;
            end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pv[i];
            req_write[i] = pw[i];
            req_addr[i*AW +: AW]  = pa[i];
            req_wdata[i*DW +: DW] = pd[i];
            req_strb[i*SW +: SW]  = ps[i];
            req_auser[i*UW +: UW] = pu[i];
        end
        #1;
        g = -1;
        if (cyc >= idle_at)
            for (int k = 0; k < N; k++)
                if (g < 0 && pv[(ptr + k) % N]) g = (ptr + k) % N;
        chk("req_ready", req_ready, (g < 0) ? 0 : N'(1) << g);
        if (g >= 0) grant(g);
    endtask

    task automatic run(input int ncyc, input bit rnd);
        bit done = 0;
        for (int k = 0; k < ncyc && !done; k++) begin
            step(rnd && k < ncyc - 150);
            done = !(rnd && k < ncyc - 150) && cyc >= idle_at && sb.size() == 0 && !pending();
        end
        chk("drain", done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE,
            PWAKEUP, PPARITY, PADDR, PWDATA, PSTRB, PPROT, PAUSER, PWUSER}, 0);
        #1 PRESET = 0;
        ptr = 0; awake = 0; idle_at = cyc;
        issue(0, 1, 5, 32'hA5A5_1234, 4'hF, 8'h11, 0, 0);
        run(30, 0);
        issue(2, 0, 5, 0, 0, 8'h22, 0, 0);
        run(30, 0);
        for (int i = 0; i < N; i++) issue(i, 0, i, 0, 0, 8'(i), 0, 0);
        run(60, 0);
        issue(3, 0, 2000, 0, 0, 8'h33, 0, 0);
        run(30, 0);
        issue(1, 0, 5, 0, 0, 8'h44, 0, 1);
        run(30, 0);
        issue(0, 1, 7, 32'h1234_5678, 4'b0110, 8'h55, 3, 0);
        run(30, 0);
        issue(1, 0, 7, 0, 0, 8'h66, TO + 4, 0);
        run(60, 0);
        issue(2, 1, 8, 32'hCAFE_F00D, 4'b0101, 8'h77, TO - 1, 0);
        run(60, 0);
        issue(3, 0, 8, 0, 0, 8'h88, 0, 0);
        run(30, 0);
        run(3000, 1);
        issue(1, 0, 3, 0, 0, 8'h99, TO + 4, 0);
        for (int k = 0; k < 10 && !(PSEL && PENABLE); k++) step(0);
        chk("reach_access", PENABLE, 1);
        @(posedge PCLK);
        #2 PRESET = 1;
        #1;
        chk("reset_abort", {PSEL, PENABLE, PWAKEUP, rsp_valid, req_ready}, 0);
        sb.delete();
        @(posedge PCLK);
        #2 PRESET = 0;
        ptr = 0; awake = 0; idle_at = cyc;
        for (int i = 0; i < N; i++) issue(i, 0, 5, 0, 0, 8'(i), 0, 0);
        run(80, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
